// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : dm_responder
// Desc     : CPU data-memory responder. Latches one request, inserts
//            WAIT_CYCLES wait states, issues one SRAM access, pulses ready.
// Revision : 1.0 - initial release
// ============================================================================
module dm_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_c_en,
    input  logic              req_r_en,
    input  logic [31:0]       req_w_en,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_w_data,
    output logic [31:0]       rsp_rd_data,
    output logic              rsp_ready,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [31:0]       sram_bweb,
    output logic [ADDR_W-3:0] sram_a,
    output logic [31:0]       sram_di,
    input  logic [31:0]       sram_do
);

    localparam logic [3:0] c_wait_init = 4'(WAIT_CYCLES);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_range_err
        $error("dm_responder: WAIT_CYCLES must be within 0..15");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_ACCESS = 3'd2,
        S_RESP   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic              w_accept;

    logic              r_lat_r_en;
    logic [31:0]       r_lat_w_en;
    logic [ADDR_W-3:0] r_lat_addr;
    logic [31:0]       r_lat_w_data;

    logic              w_lat_r_en_nxt;
    logic [31:0]       w_lat_w_en_nxt;
    logic [ADDR_W-3:0] w_lat_addr_nxt;
    logic [31:0]       w_lat_w_data_nxt;
    logic              w_go_access;
    logic              w_unused_addr_lsb;

    logic [31:0]       r_rsp_rd_data;
    logic              r_rsp_ready;
    logic              r_sram_ceb;
    logic              r_sram_web;
    logic [31:0]       r_sram_bweb;
    logic [ADDR_W-3:0] r_sram_a;
    logic [31:0]       r_sram_di;

    // Byte offset is meaningless to a word-wide SRAM.
    assign w_unused_addr_lsb = |req_addr[1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!req_c_en) begin
                    w_accept = 1'b1;
                    if (c_wait_init == 4'd0) begin
                        w_state_nxt = S_ACCESS;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = c_wait_init;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Next-value view of the latches so a zero-wait access can use the request directly.
    assign w_lat_r_en_nxt   = w_accept ? req_r_en                 : r_lat_r_en;
    assign w_lat_w_en_nxt   = w_accept ? req_w_en                 : r_lat_w_en;
    assign w_lat_addr_nxt   = w_accept ? req_addr[ADDR_W-1:2]     : r_lat_addr;
    assign w_lat_w_data_nxt = w_accept ? req_w_data               : r_lat_w_data;
    assign w_go_access      = (w_state_nxt == S_ACCESS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_lat_r_en    <= 1'b0;
            r_lat_w_en    <= '0;
            r_lat_addr    <= '0;
            r_lat_w_data  <= '0;
            r_rsp_rd_data <= '0;
            r_rsp_ready   <= 1'b0;
            r_sram_ceb    <= 1'b1;
            r_sram_web    <= 1'b1;
            r_sram_bweb   <= '1;
            r_sram_a      <= '0;
            r_sram_di     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_lat_r_en   <= w_lat_r_en_nxt;
            r_lat_w_en   <= w_lat_w_en_nxt;
            r_lat_addr   <= w_lat_addr_nxt;
            r_lat_w_data <= w_lat_w_data_nxt;

            r_sram_ceb  <= ~w_go_access;
            r_sram_web  <= w_go_access ? w_lat_r_en_nxt : 1'b1;
            r_sram_bweb <= (w_go_access && !w_lat_r_en_nxt) ? w_lat_w_en_nxt : '1;
            r_sram_a    <= w_go_access ? w_lat_addr_nxt : '0;
            r_sram_di   <= w_go_access ? w_lat_w_data_nxt : '0;

            r_rsp_ready <= (w_state_nxt == S_DONE);
            // SRAM read data is valid during RESP, one cycle after the access edge.
            if (r_state == S_RESP && r_lat_r_en) begin
                r_rsp_rd_data <= sram_do;
            end
        end
    end

    assign rsp_rd_data = r_rsp_rd_data;
    assign rsp_ready   = r_rsp_ready;
    assign sram_ceb    = r_sram_ceb;
    assign sram_web    = r_sram_web;
    assign sram_bweb   = r_sram_bweb;
    assign sram_a      = r_sram_a;
    assign sram_di     = r_sram_di;

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dm_responder
// Desc     : Self-checking bench for dm_responder with a memory-level
//            reference model and a queue-based scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_responder;

    localparam int W  = 2;
    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_c_en, req_r_en;
    logic [31:0]   req_w_en, req_w_data;
    logic [AW-1:0] req_addr;
    logic [31:0]   rsp_rd_data;
    logic          rsp_ready, sram_ceb, sram_web;
    logic [31:0]   sram_bweb, sram_di;
    logic [31:0]   sram_do = 32'h0;
    logic [AW-3:0] sram_a;

    logic          z_req_c_en, z_req_r_en;
    logic [31:0]   z_req_w_en, z_req_w_data;
    logic [AW-1:0] z_req_addr;
    logic [31:0]   z_rsp_rd_data;
    logic          z_rsp_ready, z_sram_ceb, z_sram_web;
    logic [31:0]   z_sram_bweb, z_sram_di;
    logic [31:0]   z_sram_do = 32'h0;
    logic [AW-3:0] z_sram_a;

    dm_responder #(.WAIT_CYCLES(W), .ADDR_W(AW)) u_dut (
        .clk(clk), .rst(rst), .req_c_en(req_c_en), .req_r_en(req_r_en),
        .req_w_en(req_w_en), .req_addr(req_addr), .req_w_data(req_w_data),
        .rsp_rd_data(rsp_rd_data), .rsp_ready(rsp_ready), .sram_ceb(sram_ceb),
        .sram_web(sram_web), .sram_bweb(sram_bweb), .sram_a(sram_a),
        .sram_di(sram_di), .sram_do(sram_do)
    );

    dm_responder #(.WAIT_CYCLES(0), .ADDR_W(AW)) u_dut_w0 (
        .clk(clk), .rst(rst), .req_c_en(z_req_c_en), .req_r_en(z_req_r_en),
        .req_w_en(z_req_w_en), .req_addr(z_req_addr), .req_w_data(z_req_w_data),
        .rsp_rd_data(z_rsp_rd_data), .rsp_ready(z_rsp_ready), .sram_ceb(z_sram_ceb),
        .sram_web(z_sram_web), .sram_bweb(z_sram_bweb), .sram_a(z_sram_a),
        .sram_di(z_sram_di), .sram_do(z_sram_do)
    );

    // Synchronous SRAM macro models: bit-masked write, registered read.
    logic [31:0] mem  [0:(1<<(AW-2))-1] = '{default: 32'h0};
    logic [31:0] mem0 [0:(1<<(AW-2))-1] = '{default: 32'h0};

    always @(posedge clk) begin
        if (!sram_ceb) begin
            if (sram_web) sram_do <= mem[sram_a];
            else mem[sram_a] = (mem[sram_a] & sram_bweb) | (sram_di & ~sram_bweb);
        end
        if (!z_sram_ceb) begin
            if (z_sram_web) z_sram_do <= mem0[z_sram_a];
            else mem0[z_sram_a] = (mem0[z_sram_a] & z_sram_bweb) | (z_sram_di & ~z_sram_bweb);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: word-addressed memory plus the last value returned by a read.
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd = 32'h0;

    function automatic logic [31:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    typedef struct {
        bit          is_rd;
        logic [15:0] addr;
        logic [31:0] wmask;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          acc_cyc;
    } item_t;

    item_t sb [$];
    item_t mon_it;
    int    ceb_cnt = 0;

    // Monitor: checks each SRAM access and each ready pulse against the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            ceb_cnt = 0;
        end else begin
            if (!sram_ceb) begin
                if (sb.size() == 0) begin
                    chk("spurious_access", 32'(sram_ceb), 32'h1);
                end else begin
                    mon_it = sb[0];
                    ceb_cnt++;
                    chk("access_time", 32'(cyc - mon_it.acc_cyc), 32'(W));
                    chk("sram_a", 32'(sram_a), 32'(mon_it.addr[15:2]));
                    chk("sram_web", 32'(sram_web), 32'(mon_it.is_rd));
                    chk("sram_bweb", sram_bweb, mon_it.is_rd ? 32'hFFFF_FFFF : mon_it.wmask);
                    chk("sram_di", sram_di, mon_it.wdata);
                end
            end
            if (rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_ready", 32'(rsp_ready), 32'h0);
                end else begin
                    mon_it = sb.pop_front();
                    chk("ready_latency", 32'(cyc - mon_it.acc_cyc), 32'(W + 2));
                    chk("rsp_rd_data", rsp_rd_data, mon_it.exp_rd);
                    chk("ceb_cycles", 32'(ceb_cnt), 32'h1);
                    ceb_cnt = 0;
                end
            end
        end
    end

    // Called #1 after an edge with the DUT in IDLE; returns the same way.
    task automatic issue(input bit rd, input logic [15:0] addr, input logic [31:0] mask,
                         input logic [31:0] data, input bit scramble);
        item_t it;
        bit    got;
        int    wa;
        wa          = int'(addr[15:2]);
        it.is_rd    = rd;
        it.addr     = addr;
        it.wmask    = mask;
        it.wdata    = data;
        it.acc_cyc  = cyc + 1;
        if (rd) begin
            it.exp_rd = ref_rd(wa);
            last_rd   = it.exp_rd;
        end else begin
            ref_mem[wa] = (ref_rd(wa) & mask) | (data & ~mask);
            it.exp_rd   = last_rd;
        end
        sb.push_back(it);
        req_c_en = 1'b0; req_r_en = rd; req_w_en = mask; req_addr = addr; req_w_data = data;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (rsp_ready) got = 1'b1;
            else if (scramble) begin
                req_addr   = 16'($urandom);
                req_w_data = $urandom;
                req_w_en   = $urandom;
                req_r_en   = 1'($urandom);
            end
        end
        req_c_en = 1'b1;
        if (!got) begin
            chk("ready_timeout", 32'(rsp_ready), 32'h1);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic z_txn(input bit rd, input logic [15:0] addr, input logic [31:0] data,
                         output int acc, output int rcyc, output logic [31:0] rdat,
                         output int nceb);
        bit got;
        acc  = cyc + 1;
        rcyc = -1;
        rdat = 32'h0;
        nceb = 0;
        got  = 1'b0;
        z_req_c_en = 1'b0; z_req_r_en = rd; z_req_w_en = 32'h0;
        z_req_addr = addr; z_req_w_data = data;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (!z_sram_ceb) nceb++;
            if (z_rsp_ready) begin
                got  = 1'b1;
                rcyc = cyc;
                rdat = z_rsp_rd_data;
            end
        end
        if (!got) chk("w0_ready_timeout", 32'(z_rsp_ready), 32'h1);
        @(posedge clk); #1;
        z_req_c_en = 1'b1;
    endtask

    initial begin
        int          n_rdy, n_acc, acc, rc, nc, prev_rc;
        logic [31:0] rd;
        logic [31:0] zexp [3];
        bit          rnd_rd;
        logic [15:0] rnd_addr;
        logic [31:0] rnd_mask;

        rst = 1'b0;
        req_c_en = 1'b1; req_r_en = 1'b1; req_w_en = '1; req_addr = '0; req_w_data = '0;
        z_req_c_en = 1'b1; z_req_r_en = 1'b1; z_req_w_en = '1; z_req_addr = '0; z_req_w_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(rsp_ready), 32'h0);
        chk("reset_rd_data", rsp_rd_data, 32'h0);
        chk("reset_ceb", 32'(sram_ceb), 32'h1);
        chk("reset_web", 32'(sram_web), 32'h1);
        chk("reset_bweb", sram_bweb, 32'hFFFF_FFFF);
        chk("reset_a", 32'(sram_a), 32'h0);
        chk("reset_di", sram_di, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed traffic.
        issue(1'b0, 16'h0010, 32'h0,         32'hDEAD_BEEF, 1'b0);
        issue(1'b1, 16'h0010, 32'hFFFF_FFFF, 32'h0,         1'b0);
        issue(1'b0, 16'h0020, 32'h0,         32'h1122_3344, 1'b0);
        issue(1'b0, 16'h0020, 32'hFFFF_0000, 32'hAABB_CCDD, 1'b0);
        issue(1'b1, 16'h0020, 32'hFFFF_FFFF, 32'h0,         1'b0);
        issue(1'b1, 16'h0013, 32'hFFFF_FFFF, 32'h0,         1'b0);
        issue(1'b0, 16'h0030, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
        issue(1'b1, 16'h0030, 32'h0,         32'h0,         1'b0);
        issue(1'b0, 16'h0040, 32'h0,         32'h55AA_55AA, 1'b1);
        issue(1'b1, 16'h0040, 32'hFFFF_FFFF, 32'h0,         1'b1);

        // Randomized traffic over a small, frequently-aliased address window.
        for (int i = 0; i < 40; i++) begin
            rnd_rd   = 1'($urandom_range(0, 1));
            rnd_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
            case ($urandom_range(0, 3))
                0:       rnd_mask = 32'h0;
                1:       rnd_mask = 32'hFFFF_FFFF;
                default: rnd_mask = $urandom;
            endcase
            issue(rnd_rd, rnd_addr, rnd_mask, $urandom, ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        // Reset in the middle of the WAIT phase of a read.
        issue(1'b1, 16'h0020, 32'hFFFF_FFFF, 32'h0, 1'b0);
        req_c_en = 1'b0; req_r_en = 1'b1; req_addr = 16'h0010; req_w_en = '1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        last_rd = 32'h0;
        @(negedge clk);
        chk("midreset_ceb", 32'(sram_ceb), 32'h1);
        chk("midreset_ready", 32'(rsp_ready), 32'h0);
        chk("midreset_rd_data", rsp_rd_data, 32'h0);
        @(posedge clk); #1;
        req_c_en = 1'b1;
        rst = 1'b1;
        n_rdy = 0;
        n_acc = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_ready) n_rdy++;
            if (!sram_ceb) n_acc++;
        end
        chk("no_ready_after_reset", 32'(n_rdy), 32'h0);
        chk("no_access_after_reset", 32'(n_acc), 32'h0);
        @(posedge clk); #1;
        issue(1'b1, 16'h0020, 32'hFFFF_FFFF, 32'h0, 1'b0);

        // Zero-wait instance: preload three words, then three back-to-back reads.
        zexp[0] = 32'hA5A5_0001;
        zexp[1] = 32'h5A5A_0002;
        zexp[2] = 32'h0F0F_0003;
        for (int i = 0; i < 3; i++) begin
            z_txn(1'b0, 16'(4 * (i + 1)), zexp[i], acc, rc, rd, nc);
            chk("w0_write_ceb_cycles", 32'(nc), 32'h1);
        end
        prev_rc = -1;
        for (int i = 0; i < 3; i++) begin
            z_txn(1'b1, 16'(4 * (i + 1)), 32'h0, acc, rc, rd, nc);
            chk("w0_rd_data", rd, zexp[i]);
            chk("w0_ceb_cycles", 32'(nc), 32'h1);
            chk("w0_latency", 32'(rc - acc), 32'h2);
            if (i > 0) chk("w0_ready_spacing", 32'(rc - prev_rc), 32'h4);
            prev_rc = rc;
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Memory-side responder for the CPU data-memory port. Accepts one CPU DM request at a time, applies a programmable number of wait states, then performs a single access on a synchronous SRAM_wrapper-style macro.
- Returns read data with a one-cycle ready pulse, which gives the CPU a realistic multi-cycle memory model.
- Placement: between the CPU DM port and the DM SRAM_wrapper instance in top.

Parameters:
- WAIT_CYCLES, 2, wait-state cycles inserted before the SRAM access; legal range 0..15.
- ADDR_W, 16, CPU byte-address width; SRAM word address is ADDR_W-2 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_c_en  in  1  request valid, active-low (0 = request present).
- req_r_en  in  1  1 = read, 0 = write.
- req_w_en  in  32  per-bit write mask, active-low; ignored on reads.
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- req_w_data  in  32  write data.
- rsp_rd_data  out  32  last read data, held until the next read completes.
- rsp_ready  out  1  one-cycle completion pulse, for reads and writes.
- sram_ceb  out  1  SRAM chip enable, active-low.
- sram_web  out  1  SRAM write enable, active-low.
- sram_bweb  out  32  SRAM bit write enable, active-low.
- sram_a  out  ADDR_W-2  SRAM word address.
- sram_di  out  32  SRAM write data.
- sram_do  in  32  SRAM read data, valid the cycle after the access edge.

Behaviour:
- Reset (rst=0, any time, including mid-transaction):
  - State = IDLE; wait counter = 0; request latches cleared.
  - Outputs: rsp_ready=0, rsp_rd_data=0, sram_ceb=1, sram_web=1, sram_bweb=32'hFFFFFFFF, sram_a=0, sram_di=0.
  - An in-flight access is abandoned and no ready pulse is issued.
- All outputs are registered.
- States: IDLE, WAIT, ACCESS, RESP, DONE.
- IDLE:
  - On a rising edge with req_c_en=0, latch r_en, w_en, addr[ADDR_W-1:2] and w_data.
  - Next state is WAIT with counter = WAIT_CYCLES, or ACCESS directly if WAIT_CYCLES=0.
  - With req_c_en=1 the block stays in IDLE.
- WAIT:
  - Counter decrements each edge; when it equals 1, the next state is ACCESS.
  - SRAM signals stay idle (sram_ceb=1).
  - Request inputs are ignored here and in every state except IDLE.
- ACCESS (exactly one cycle):
  - sram_ceb=0 and sram_web=latched r_en.
  - sram_bweb = latched w_en on a write, 32'hFFFFFFFF on a read.
  - sram_a and sram_di driven from the latches.
  - Next state is RESP.
- RESP:
  - SRAM signals return to idle values.
  - On a read, sram_do is captured into rsp_rd_data at the edge leaving RESP.
  - On a write, rsp_rd_data is unchanged.
  - Next state is DONE.
- DONE:
  - rsp_ready=1 for this cycle only; next state is IDLE unconditionally.
- Latency:
  - Request accepted at edge k; rsp_ready is high in the cycle after edge k+WAIT_CYCLES+2.
  - This gives one transaction per WAIT_CYCLES+4 cycles including the IDLE sampling cycle.
- Handshake:
  - The CPU holds the request stable until it sees rsp_ready.
  - A request presented in the cycle after the ready pulse (IDLE) is accepted normally, so back-to-back transactions are legal.
  - If the CPU keeps req_c_en=0 with unchanged fields after ready, this is treated as a new request. This is a protocol obligation on the CPU, not an error.
- A write mask of all ones still performs the ACCESS cycle and pulses ready; memory contents are unchanged.
- Address wrap: sram_a is a pure truncation; no range check is made.
- Counter width is 4 bits; WAIT_CYCLES > 15 is illegal and is flagged by an elaboration-time assertion.

Test Plan:
- Reset: drive rst=0 mid-WAIT of a read -> next cycle sram_ceb=1, rsp_ready=0, rsp_rd_data=0; no ready pulse after rst=1 with req_c_en=1.
- Write then read, WAIT_CYCLES=2: write 0xDEADBEEF to 0x0010 with mask 0, then read 0x0010:
  - Each rsp_ready pulse appears exactly 4 edges after acceptance.
  - rsp_rd_data=0xDEADBEEF.
  - sram_a=0x0004 during ACCESS.
- Partial write: preload 0x11223344 at 0x0020, write 0xAABBCCDD with req_w_en=0xFFFF0000 -> read returns 0x1122CCDD.
- WAIT_CYCLES=0 back-to-back: three reads issued immediately after each ready -> ready pulses 4 cycles apart; sram_ceb low exactly one cycle per transaction.
- Inputs ignored while busy: change req_addr and req_w_data during WAIT/ACCESS -> SRAM sees only the values latched at acceptance.
- Misaligned address: read 0x0013 after writing 0x0010 -> same data as 0x0010; sram_a=0x0004.
